// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, constants and the baud divisor helper.
//               The PARITY state exists only when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Clock cycles per oversample tick, integer division.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running one-cycle tick every DIV clocks, with a
//               synchronous clear that restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == C_TOP) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == C_TOP);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserializer
// Description : Oversampling UART receiver, 8 data bits LSB first, 1 stop bit.
//               Define UART_RX_PARITY_EN for an even-parity bit and the
//               parity_err strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 19_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err_tick,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] C_MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] C_LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

  // Synchronizer plus one history flop for falling-edge detection.
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rx_s;
  logic w_fall;
  logic w_clr;
  logic w_tick;

  rx_state_t               state_q;
  logic [SW-1:0]           s_cnt_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [DATA_BITS-1:0]    shift_q;
  logic [DATA_BITS-1:0]    dout_q;
  logic                    done_q;
  logic                    ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                    par_q;
  logic                    perr_q;
`endif

  // Two-flop synchronizer on the async line, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_Rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s   = sync2_q;
  assign w_fall = prev_q & ~rx_s;
  // Restart the tick phase at the start-bit edge so sampling is centred.
  assign w_clr  = (state_q == ST_IDLE) && w_fall;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Receive state machine with registered data and strobe outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_fall) begin
            state_q <= ST_START;
            s_cnt_q <= '0;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (s_cnt_q == C_MID) begin
              s_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (s_cnt_q == C_LAST) begin
              s_cnt_q <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            if (s_cnt_q == C_LAST) begin
              s_cnt_q <= '0;
              par_q   <= rx_s;
              state_q <= ST_STOP;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (w_tick) begin
            if (s_cnt_q == C_LAST) begin
              s_cnt_q <= '0;
              if (rx_s) begin
                state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                // Even parity: data bits xor parity bit must be zero.
                if ((^shift_q) ^ par_q) begin
                  perr_q <= 1'b1;
                end else begin
                  dout_q <= shift_q;
                  done_q <= 1'b1;
                end
`else
                dout_q <= shift_q;
                done_q <= 1'b1;
`endif
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end

        ST_BREAK: begin
          // Line must return high before a new start bit is accepted.
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout           = dout_q;
  assign rx_done_tick   = done_q;
  assign frame_err_tick = ferr_q;
  assign busy           = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err     = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Directed, table-driven bench for the UART receiver.
//               1.6 MHz clock, 10 kbaud, 16x oversample: one bit = 160 clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

  localparam int BIT_CLK = 160;

  logic       clk;
  logic       rst_n;
  logic       i_Rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err_tick;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_deserializer #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_Rx           (i_Rx),
    .dout           (dout),
    .rx_done_tick   (rx_done_tick),
    .frame_err_tick (frame_err_tick),
    .busy           (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err     (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;
  int done_cnt;
  int ferr_cnt;
  int perr_cnt;
  int viol;
  logic prev_busy;
  logic prev_done;
  logic prev_ferr;
  logic par_flip;

  // Strobe monitor, sampled on the falling edge away from the active edge.
  initial begin
    done_cnt = 0; ferr_cnt = 0; perr_cnt = 0; viol = 0;
    prev_busy = 1'b0; prev_done = 1'b0; prev_ferr = 1'b0;
  end

  always @(negedge clk) begin
    logic perr_now;
`ifdef UART_RX_PARITY_EN
    perr_now = parity_err;
`else
    perr_now = 1'b0;
`endif
    if (rst_n) begin
      if (rx_done_tick) begin
        done_cnt++;
        if (busy || !prev_busy) viol++;
      end
      if (frame_err_tick) ferr_cnt++;
      if (perr_now) perr_cnt++;
      if (int'(rx_done_tick) + int'(frame_err_tick) + int'(perr_now) > 1) viol++;
      if ((rx_done_tick && prev_done) || (frame_err_tick && prev_ferr)) viol++;
    end
    prev_busy = busy;
    prev_done = rx_done_tick;
    prev_ferr = frame_err_tick;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic drive(input logic v, input int n);
    i_Rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit, idle gap.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int gap);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip, BIT_CLK);
`endif
    if (stop_low > 0) drive(1'b0, stop_low);
    else              drive(1'b1, BIT_CLK);
    i_Rx = 1'b1;
    if (gap > 0) drive(1'b1, gap);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         gap;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0;
    int f0;
    int p0;
    n_total = 0;
    n_pass  = 0;
    par_flip = 1'b0;
    rst_n = 1'b0;
    i_Rx  = 1'b1;

    vecs[0] = '{8'hA5, 0,   40,  1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 480, 200, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 0,   40,  1, 0, 8'h81};
    vecs[3] = '{8'h00, 0,   0,   1, 0, 8'h00};
    vecs[4] = '{8'hFF, 0,   40,  1, 0, 8'hFF};

    // Reset state.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_done", int'(rx_done_tick), 0);
    check("rst_ferr", int'(frame_err_tick), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 50);

    // Table of frames: good, framing error + break, recovery, back-to-back.
    for (int k = 0; k < 5; k++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].stop_low, vecs[k].gap);
      check($sformatf("vec%0d_done", k), done_cnt - d0, vecs[k].exp_done);
      check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_dout", k), int'(dout), int'(vecs[k].exp_dout));
    end

    // Short low glitch on the idle line.
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive(1'b0, 40);
    drive(1'b1, 400);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_dout", int'(dout), 8'hFF);
    check("glitch_busy", int'(busy), 0);

    // Reset in the middle of data bit 4, then a fresh frame.
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive(1'b0, BIT_CLK);
    drive(1'b1, BIT_CLK);
    drive(1'b1, BIT_CLK);
    drive(1'b0, BIT_CLK);
    drive(1'b0, BIT_CLK);
    drive(1'b0, BIT_CLK / 2);
    check("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_Rx  = 1'b1;
    drive(1'b1, 400);
    check("midrst_done", done_cnt - d0, 0);
    check("midrst_ferr", ferr_cnt - f0, 0);
    check("midrst_dout", int'(dout), 0);
    d0 = done_cnt;
    send_frame(8'h5A, 0, 40);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_dout", int'(dout), 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit, then correct parity.
    d0 = done_cnt;
    p0 = perr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 0, 40);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_done", done_cnt - d0, 0);
    check("par_bad_dout", int'(dout), 8'h5A);
    d0 = done_cnt;
    p0 = perr_cnt;
    par_flip = 1'b0;
    send_frame(8'h07, 0, 40);
    check("par_ok_perr", perr_cnt - p0, 0);
    check("par_ok_done", done_cnt - d0, 1);
    check("par_ok_dout", int'(dout), 8'h07);
`else
    p0 = perr_cnt;
    check("no_parity_strobes", p0, 0);
`endif

    // Strobe exclusivity, width and busy alignment across the whole run.
    check("strobe_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
